// File: rtl/riscv_program_loader_ctrl.sv
// Boot loader sequencer: length-prefixed UART byte image -> 32-bit memory writes, then CPU release.
// Optional trailing checksum when LOADER_CHECKSUM_EN is defined.
module riscv_program_loader_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        cpu_rst_n,
    output logic        loading_complete,
    output logic        load_error
);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_field;
    logic [31:0] r_n;
    logic [31:0] r_word_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_csum;
`endif

    logic        w_rx_fire;
    logic [31:0] w_field;
    logic        w_last_word;

    // Header/checksum fields are shifted in LSB first; the 4th byte completes them combinationally.
    assign w_field     = {rx_data, r_field};
    assign w_rx_fire   = rx_valid && rx_ready;
    assign w_last_word = (r_word_cnt == (r_n - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HDR;
            r_byte_cnt <= 2'd0;
            r_field    <= 24'd0;
            r_n        <= 32'd0;
            r_word_cnt <= 32'd0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_HDR: begin
                    if (w_rx_fire) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_field    <= w_field[31:8];
                        if (r_byte_cnt == 2'd3) begin
                            if ((w_field == 32'd0) || (w_field > MAX_N)) begin
                                r_state <= S_ERR;
                            end else begin
                                r_n     <= w_field;
                                r_state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_wdata[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        r_word_cnt <= r_word_cnt + 32'd1;
                        r_addr     <= r_addr + 32'd4;
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= r_csum + r_wdata;
                        r_state    <= w_last_word ? S_CSUM : S_DATA;
`else
                        r_state    <= w_last_word ? S_DONE : S_DATA;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_rx_fire) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_field    <= w_field[31:8];
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= (w_field == r_csum) ? S_DONE : S_ERR;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    // Outputs decode directly from the state register so reset removes mem_req asynchronously.
    assign rx_ready         = (r_state == S_HDR) || (r_state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                              || (r_state == S_CSUM)
`endif
                              ;
    assign mem_req          = (r_state == S_WRITE);
    assign mem_addr         = r_addr;
    assign mem_wdata        = r_wdata;
    assign cpu_rst_n        = (r_state == S_DONE);
    assign loading_complete = (r_state == S_DONE);
    assign load_error       = (r_state == S_ERR);

endmodule
